// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding
// and the default sequential increment.
package pc_seq_pkg;

   // Run/halt state of the sequencer
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Bytes per instruction for a plain sequential step
   localparam int unsigned DEFAULT_INC = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry and keeps the count at DEPTH; a pop from an empty stack is
// ignored. ovf/unf flag those two cases in the cycle they are requested.
module ras_stack #(
   parameter int unsigned W     = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         full,
   output logic         ovf,
   output logic         unf
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;   // next slot to write
   logic [PTR_W-1:0] top_ptr;  // most recent entry
   logic [PTR_W-1:0] nxt_ptr;
   logic [CNT_W-1:0] count;

   // Pointer arithmetic modulo DEPTH and status flags
   always_comb begin
      top_ptr = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
      nxt_ptr = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      empty   = (count == '0);
      full    = (count == CNT_W'(DEPTH));
      dout    = mem[top_ptr];
      ovf     = push & full;
      unf     = pop & empty;
   end

   // Pointer and occupancy; when full, wr_ptr already sits on the oldest entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (push) begin
         wr_ptr <= nxt_ptr;
         if (!full) begin
            count <= count + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         wr_ptr <= top_ptr;
         count  <= count - CNT_W'(1);
      end
   end

   // Entry storage needs no reset; count gates validity
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: holds the fetch PC, picks the next
// address (sequential, branch, call, return), owns the return-address stack
// and a run/halt state machine.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned      ADDR_W    = 32,
   parameter int unsigned      INC       = DEFAULT_INC,
   parameter int unsigned      RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic              is_call,
   input  logic              is_ret,
   input  logic [ADDR_W-1:0] branch_target,
   input  logic              halt_req,
   input  logic              resume,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_seq,
   output logic              flush,
   output logic              halted,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_err
);

   state_t            state;
   logic              active;
   logic              ras_push;
   logic              ras_pop;
   logic [ADDR_W-1:0] ras_top;
   logic              ras_ovf;
   logic              ras_unf;

   // Link value and RAS requests; the stack only moves when the core is
   // running, not stalled, and no halt is being taken this cycle
   always_comb begin
      pc_seq   = pc + ADDR_W'(INC);
      active   = !stall && (state == ST_RUN) && !halt_req;
      ras_pop  = active && is_ret;
      ras_push = active && is_call && !is_ret;
   end

   ras_stack #(
      .W     (ADDR_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc_seq),
      .dout  (ras_top),
      .empty (ras_empty),
      .full  (ras_full),
      .ovf   (ras_ovf),
      .unf   (ras_unf)
   );

   // FSM, PC register and registered flags in priority order
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc      <= RESET_VEC;
         state   <= ST_RUN;
         flush   <= 1'b0;
         halted  <= 1'b0;
         ras_err <= 1'b0;
      end else if (stall) begin
         flush <= 1'b0;
      end else begin
         unique case (state)
            ST_HALT: begin
               flush <= 1'b0;
               if (resume) begin
                  state  <= ST_RUN;
                  halted <= 1'b0;
               end
            end
            ST_RUN: begin
               if (halt_req) begin
                  state  <= ST_HALT;
                  halted <= 1'b1;
                  flush  <= 1'b0;
               end else if (is_ret) begin
                  if (ras_empty) begin
                     pc    <= pc_seq;
                     flush <= 1'b0;
                  end else begin
                     pc    <= ras_top;
                     flush <= 1'b1;
                  end
               end else if (is_call || branch_taken) begin
                  pc    <= branch_target;
                  flush <= 1'b1;
               end else begin
                  pc    <= pc_seq;
                  flush <= 1'b0;
               end
               // Sticky until reset
               if (ras_ovf || ras_unf) begin
                  ras_err <= 1'b1;
               end
            end
            default: begin
               state <= ST_RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed stimulus, a queue-based reference model
// checked every cycle, plus literal expectations on key points. A second,
// 8-bit instance shares the controls and must track the model modulo 256.
module tb_pc_sequencer;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, branch_taken = 1'b0, is_call = 1'b0, is_ret = 1'b0;
   logic        halt_req = 1'b0, resume = 1'b0;
   logic [31:0] target = '0;

   logic [31:0] pc, pc_seq;
   logic        flush, halted, ras_empty, ras_full, ras_err;
   logic [7:0]  pc8, pc_seq8;
   logic        flush8, halted8, ras_empty8, ras_full8, ras_err8;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   pc_sequencer #(.ADDR_W(32), .INC(4), .RAS_DEPTH(DEPTH), .RESET_VEC(32'h0)) u_dut (
      .clk (clk), .rst (rst), .stall (stall), .branch_taken (branch_taken),
      .is_call (is_call), .is_ret (is_ret), .branch_target (target),
      .halt_req (halt_req), .resume (resume), .pc (pc), .pc_seq (pc_seq),
      .flush (flush), .halted (halted), .ras_empty (ras_empty),
      .ras_full (ras_full), .ras_err (ras_err)
   );

   pc_sequencer #(.ADDR_W(8), .INC(4), .RAS_DEPTH(DEPTH), .RESET_VEC(8'h0)) u_dut8 (
      .clk (clk), .rst (rst), .stall (stall), .branch_taken (branch_taken),
      .is_call (is_call), .is_ret (is_ret), .branch_target (target[7:0]),
      .halt_req (halt_req), .resume (resume), .pc (pc8), .pc_seq (pc_seq8),
      .flush (flush8), .halted (halted8), .ras_empty (ras_empty8),
      .ras_full (ras_full8), .ras_err (ras_err8)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: PC as a number, RAS as a bounded queue of links
   logic [31:0] m_pc;
   logic        m_flush, m_halt, m_err;
   logic [31:0] m_ras [$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_flush = 0; m_halt = 0; m_err = 0;
         m_ras.delete();
      end else if (stall) begin
         m_flush = 0;
      end else if (m_halt) begin
         m_flush = 0;
         if (resume) m_halt = 0;
      end else if (halt_req) begin
         m_halt = 1; m_flush = 0;
      end else if (is_ret) begin
         if (m_ras.size() == 0) begin
            m_pc = m_pc + 32'd4; m_err = 1; m_flush = 0;
         end else begin
            m_pc = m_ras.pop_back(); m_flush = 1;
         end
      end else if (is_call) begin
         if (m_ras.size() == DEPTH) begin
            void'(m_ras.pop_front());
            m_err = 1;
         end
         m_ras.push_back(m_pc + 32'd4);
         m_pc = target; m_flush = 1;
      end else if (branch_taken) begin
         m_pc = target; m_flush = 1;
      end else begin
         m_pc = m_pc + 32'd4; m_flush = 0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (check_en && !rst) begin
         logic [31:0] nxt;
         nxt = m_pc + 32'd4;
         chk("pc", pc, m_pc);
         chk("pc_seq", pc_seq, nxt);
         chk("flush", {31'b0, flush}, {31'b0, m_flush});
         chk("halted", {31'b0, halted}, {31'b0, m_halt});
         chk("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
         chk("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
         chk("ras_err", {31'b0, ras_err}, {31'b0, m_err});
         chk("pc8", {24'b0, pc8}, {24'b0, m_pc[7:0]});
         chk("pc_seq8", {24'b0, pc_seq8}, {24'b0, nxt[7:0]});
         chk("flush8", {31'b0, flush8}, {31'b0, m_flush});
         chk("halted8", {31'b0, halted8}, {31'b0, m_halt});
         chk("ras_err8", {31'b0, ras_err8}, {31'b0, m_err});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic call_to(input logic [31:0] t);
      is_call = 1'b1; target = t;
      cyc();
      is_call = 1'b0;
   endtask

   task automatic ret_once();
      is_ret = 1'b1;
      cyc();
      is_ret = 1'b0;
   endtask

   logic [31:0] held;
   logic [31:0] links [4];

   initial begin
      links[0] = 32'h4004; links[1] = 32'h3004; links[2] = 32'h2004; links[3] = 32'h1004;

      // Reset and sequential stepping
      repeat (2) cyc();
      chk("rst_pc", pc, 32'h0);
      chk("rst_empty", {31'b0, ras_empty}, 32'd1);
      rst = 1'b0;
      check_en = 1'b1;
      cyc(); chk("seq_4", pc, 32'h4);
      cyc(); chk("seq_8", pc, 32'h8);
      repeat (14) cyc();
      chk("pc_40", pc, 32'h40);
      #2 rst = 1'b1;
      #1 chk("async_rst_pc", pc, 32'h0);
      chk("async_rst_err", {31'b0, ras_err}, 32'd0);
      #1 rst = 1'b0;
      cyc(); chk("post_rst_4", pc, 32'h4);
      cyc(); chk("post_rst_8", pc, 32'h8);

      // Branch with one-cycle flush
      repeat (2) cyc();
      chk("pc_10", pc, 32'h10);
      branch_taken = 1'b1; target = 32'h100;
      cyc(); branch_taken = 1'b0;
      chk("br_pc", pc, 32'h100);
      chk("br_flush", {31'b0, flush}, 32'd1);
      cyc();
      chk("br_pc_next", pc, 32'h104);
      chk("br_flush_clr", {31'b0, flush}, 32'd0);

      // Call and return
      branch_taken = 1'b1; target = 32'h20;
      cyc(); branch_taken = 1'b0;
      call_to(32'h200);
      chk("call_pc", pc, 32'h200);
      chk("call_nonempty", {31'b0, ras_empty}, 32'd0);
      ret_once();
      chk("ret_pc", pc, 32'h24);
      chk("ret_empty", {31'b0, ras_empty}, 32'd1);
      chk("ret_err", {31'b0, ras_err}, 32'd0);

      // Overflow: five nested calls into a four-deep stack
      for (int i = 1; i <= 5; i++) call_to(32'(i) << 12);
      chk("ovf_pc", pc, 32'h5000);
      chk("ovf_full", {31'b0, ras_full}, 32'd1);
      chk("ovf_err", {31'b0, ras_err}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         ret_once();
         chk("ovf_ret_link", pc, links[i]);
      end
      chk("drained_empty", {31'b0, ras_empty}, 32'd1);
      ret_once();
      chk("unf_pc", pc, 32'h1008);
      chk("unf_flush", {31'b0, flush}, 32'd0);

      // Call and return together behave as return
      call_to(32'h300);
      is_call = 1'b1; is_ret = 1'b1; target = 32'h900;
      cyc(); is_call = 1'b0; is_ret = 1'b0;
      chk("callret_pc", pc, 32'h100c);
      chk("callret_empty", {31'b0, ras_empty}, 32'd1);

      // Stall ignores branch
      held = pc;
      stall = 1'b1; branch_taken = 1'b1; target = 32'h777;
      cyc(); stall = 1'b0; branch_taken = 1'b0;
      chk("stall_pc", pc, held);
      chk("stall_flush", {31'b0, flush}, 32'd0);

      // Halt freezes PC and ignores redirects; resume restarts stepping
      halt_req = 1'b1;
      cyc(); halt_req = 1'b0;
      chk("halted", {31'b0, halted}, 32'd1);
      branch_taken = 1'b1; is_call = 1'b1; target = 32'h888;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("halt_pc", pc, held);
      end
      branch_taken = 1'b0; is_call = 1'b0;
      chk("halt_ras_frozen", {31'b0, ras_empty}, 32'd1);
      resume = 1'b1;
      cyc(); resume = 1'b0;
      chk("resume_halted", {31'b0, halted}, 32'd0);
      chk("resume_pc", pc, held);
      cyc();
      chk("resume_step", pc, held + 32'd4);

      // Wrap at the top of the address space
      branch_taken = 1'b1; target = 32'hffff_fffc;
      cyc(); branch_taken = 1'b0;
      chk("wrap8_pc", {24'b0, pc8}, 32'hfc);
      chk("wrap8_seq", {24'b0, pc_seq8}, 32'h0);
      cyc();
      chk("wrap8_next", {24'b0, pc8}, 32'h0);
      chk("wrap32_next", pc, 32'h0);
      cyc();

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
